// File: rtl/ts_lamp_monitor.sv
// Conflict and timing watchdog for the six traffic lamp drives: decodes phases,
// checks their order and durations, and latches a fault that requests flash-red.
module ts_lamp_monitor #(
  parameter int CLK_FREQ       = 50000000,
  parameter int HWY_GRN_MIN_S  = 60,
  parameter int YEL_MIN_S      = 10,
  parameter int CTRY_GRN_MAX_S = 31,
  parameter int TOL_S          = 1
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       R_ctry,
  input  logic       G_ctry,
  input  logic       Y_ctry,
  input  logic       R_hiwy,
  input  logic       G_hiwy,
  input  logic       Y_hiwy,
  input  logic       fault_ack,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red
);

  // state  | meaning
  // INIT   | waiting for the first legal pattern after reset or fault_ack
  // TRACK  | following a legal phase, checking order and durations
  // FAULT  | fault latched, lamps ignored until fault_ack
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [1:0] PH_HG = 2'd0;
  localparam logic [1:0] PH_HY = 2'd1;
  localparam logic [1:0] PH_CG = 2'd2;
  localparam logic [1:0] PH_CY = 2'd3;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_SEQ     = 3'd2;
  localparam logic [2:0] FC_SHORT_G = 3'd3;
  localparam logic [2:0] FC_SHORT_Y = 3'd4;
  localparam logic [2:0] FC_LONG_Y  = 3'd5;
  localparam logic [2:0] FC_LONG_CG = 3'd6;

  localparam logic [6:0] HG_MIN = 7'(HWY_GRN_MIN_S - TOL_S);
  localparam logic [6:0] YL_MIN = 7'(YEL_MIN_S - TOL_S);
  localparam logic [6:0] YL_MAX = 7'(YEL_MIN_S + TOL_S);
  localparam logic [6:0] CG_MAX = 7'(CTRY_GRN_MAX_S + TOL_S);

  logic [5:0]    lamp_q, lamp_d;
  logic          lamp_vld_q, lamp_vld_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [6:0]    elapsed_q, elapsed_d;
  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic          first_q, first_d;
  logic [2:0]    fault_code_q, fault_code_d;

  logic          sec_tick;
  logic          pat_legal;
  logic [1:0]    pat_phase;
  logic [1:0]    phase_nxt;
  logic          phase_chg;
  logic [2:0]    det_code;
  logic [6:0]    elapsed_inc;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      lamp_q       <= '0;
      lamp_vld_q   <= 1'b0;
      tick_cnt_q   <= '0;
      elapsed_q    <= '0;
      state_q      <= ST_INIT;
      phase_q      <= PH_HG;
      first_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      lamp_q       <= lamp_d;
      lamp_vld_q   <= lamp_vld_d;
      tick_cnt_q   <= tick_cnt_d;
      elapsed_q    <= elapsed_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      first_q      <= first_d;
      fault_code_q <= fault_code_d;
    end
  end

  // lamp_vld masks the all-off reset value of the lamp register for one cycle
  assign lamp_d     = {R_hiwy, G_hiwy, Y_hiwy, R_ctry, G_ctry, Y_ctry};
  assign lamp_vld_d = 1'b1;

  assign sec_tick   = (tick_cnt_q == TW'(CLK_FREQ - 1));
  assign tick_cnt_d = sec_tick ? '0 : tick_cnt_q + TW'(1);

  assign elapsed_inc = (sec_tick && (elapsed_q != 7'd127)) ? elapsed_q + 7'd1 : elapsed_q;

  always_comb begin
    pat_legal = 1'b1;
    pat_phase = PH_HG;
    case (lamp_q)
      6'b010_100: pat_phase = PH_HG;
      6'b001_100: pat_phase = PH_HY;
      6'b100_010: pat_phase = PH_CG;
      6'b100_001: pat_phase = PH_CY;
      default:    pat_legal = 1'b0;
    endcase
  end

  assign phase_nxt = phase_q + 2'd1;
  assign phase_chg = pat_legal && (pat_phase != phase_q);

  // lower-priority causes are evaluated first so higher ones overwrite them
  always_comb begin
    det_code = FC_NONE;
    if (state_q == ST_TRACK) begin
      case (phase_q)
        PH_HY, PH_CY: if (elapsed_q > YL_MAX) det_code = FC_LONG_Y;
        PH_CG:        if (elapsed_q > CG_MAX) det_code = FC_LONG_CG;
        default:      ;
      endcase
      if (phase_chg) begin
        if (pat_phase != phase_nxt) begin
          det_code = FC_SEQ;
        end else if (!first_q) begin
          case (phase_q)
            PH_HG:        if (elapsed_q < HG_MIN) det_code = FC_SHORT_G;
            PH_HY, PH_CY: if (elapsed_q < YL_MIN) det_code = FC_SHORT_Y;
            default:      ;
          endcase
        end
      end
      if (!pat_legal) det_code = FC_ILLEGAL;
    end else if (state_q == ST_INIT) begin
      if (lamp_vld_q && !pat_legal) det_code = FC_ILLEGAL;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    first_d      = first_q;
    fault_code_d = fault_code_q;
    elapsed_d    = elapsed_inc;
    case (state_q)
      ST_INIT: begin
        elapsed_d = '0;
        if (det_code != FC_NONE) begin
          state_d      = ST_FAULT;
          fault_code_d = det_code;
        end else if (lamp_vld_q) begin
          state_d = ST_TRACK;
          phase_d = pat_phase;
          first_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (det_code != FC_NONE) begin
          state_d      = ST_FAULT;
          fault_code_d = det_code;
        end else if (phase_chg) begin
          phase_d   = pat_phase;
          first_d   = 1'b0;
          elapsed_d = '0;
        end
      end
      ST_FAULT: begin
        elapsed_d = '0;
        if (fault_ack) begin
          state_d      = ST_INIT;
          fault_code_d = FC_NONE;
        end
      end
      default: begin
        state_d   = ST_INIT;
        elapsed_d = '0;
      end
    endcase
  end

  assign phase       = phase_q;
  assign phase_valid = (state_q == ST_TRACK);
  assign fault       = (state_q == ST_FAULT);
  assign flash_red   = (state_q == ST_FAULT);
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_ts_lamp_monitor.sv
// Directed bench for ts_lamp_monitor with a 10-cycle second.
module tb_ts_lamp_monitor;
  localparam int CF = 10;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       R_ctry, G_ctry, Y_ctry, R_hiwy, G_hiwy, Y_hiwy;
  logic       fault_ack = 1'b0;
  logic [1:0] phase;
  logic       phase_valid, fault, flash_red;
  logic [2:0] fault_code;

  int vecs = 0;
  int errs = 0;
  int edge_cnt;

  ts_lamp_monitor #(.CLK_FREQ(CF)) dut (
    .clk(clk), .clear_n(clear_n),
    .R_ctry(R_ctry), .G_ctry(G_ctry), .Y_ctry(Y_ctry),
    .R_hiwy(R_hiwy), .G_hiwy(G_hiwy), .Y_hiwy(Y_hiwy),
    .fault_ack(fault_ack), .phase(phase), .phase_valid(phase_valid),
    .fault(fault), .fault_code(fault_code), .flash_red(flash_red)
  );

  always #5 clk = ~clk;

  // edge_cnt equals the DUT tick counter (mod CF) after each edge
  always @(posedge clk or negedge clear_n)
    if (!clear_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;

  task step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task hold(input int s);
    step(s * CF);
  endtask

  task set_l(input logic [2:0] h, input logic [2:0] c);
    {R_hiwy, G_hiwy, Y_hiwy} = h;
    {R_ctry, G_ctry, Y_ctry} = c;
  endtask

  task set_ph(input int p);
    case (p)
      0: set_l(3'b010, 3'b100);
      1: set_l(3'b001, 3'b100);
      2: set_l(3'b100, 3'b010);
      default: set_l(3'b100, 3'b001);
    endcase
  endtask

  task do_reset(input int p);
    fault_ack = 1'b0;
    set_ph(p);
    clear_n = 1'b0;
    step(2);
    clear_n = 1'b1;
  endtask

  // first edge that increments elapsed once a phase is registered at edge p
  function automatic int first_tick(input int p);
    return ((p + 2 + CF - 1) / CF) * CF;
  endfunction

  task wait_edge(input int target);
    int guard;
    guard = 0;
    while (edge_cnt < target && guard < 5000) begin
      step(1);
      guard++;
    end
    vecs++;
    if (edge_cnt !== target) begin
      $display("FAIL wait_edge: reached %0d, required %0d", edge_cnt, target);
      errs++;
    end
  endtask

  task run_cycle();
    int exp_ph[4] = '{0, 1, 2, 3};
    int dur[4]    = '{62, 10, 20, 10};
    for (int i = 0; i < 4; i++) begin
      hold(dur[i]);
      vecs++;
      if (phase !== 2'(exp_ph[i]) || fault !== 1'b0) begin
        $display("FAIL cycle_ph%0d: phase=%0d fault=%0b, required phase=%0d fault=0",
                 i, phase, fault, exp_ph[i]);
        errs++;
      end
      set_ph((i + 1) % 4);
    end
    hold(1);
    vecs++;
    if (phase !== 2'd0 || fault !== 1'b0 || phase_valid !== 1'b1) begin
      $display("FAIL cycle_wrap: phase=%0d fault=%0b valid=%0b, required 0/0/1",
               phase, fault, phase_valid);
      errs++;
    end
  endtask

  task test_reset();
    set_ph(0);
    clear_n = 1'b0;
    #3;
    vecs++;
    if ({fault, flash_red, fault_code, phase_valid, phase} !== 8'd0) begin
      $display("FAIL reset_outputs: got %b, required 00000000",
               {fault, flash_red, fault_code, phase_valid, phase});
      errs++;
    end
    do_reset(0);
    step(1);
    vecs++;
    if (phase_valid !== 1'b0) begin
      $display("FAIL reset_valid_early: phase_valid=%0b, required 0", phase_valid);
      errs++;
    end
    step(1);
    vecs++;
    if (phase_valid !== 1'b1 || phase !== 2'd0 || fault !== 1'b0) begin
      $display("FAIL reset_lock: valid=%0b phase=%0d fault=%0b, required 1/0/0",
               phase_valid, phase, fault);
      errs++;
    end
  endtask

  task test_full_cycle();
    do_reset(0);
    step(2);
    run_cycle();
  endtask

  task test_illegal();
    do_reset(0);
    step(5);
    set_l(3'b010, 3'b010);
    step(1);
    vecs++;
    if (fault !== 1'b0) begin
      $display("FAIL illegal_early: fault=%0b, required 0", fault);
      errs++;
    end
    step(1);
    vecs++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || flash_red !== 1'b1 || phase_valid !== 1'b0) begin
      $display("FAIL illegal: fault=%0b code=%0d flash=%0b valid=%0b, required 1/1/1/0",
               fault, fault_code, flash_red, phase_valid);
      errs++;
    end
  endtask

  task expect_code_after_change(input string name, input logic [2:0] code);
    step(1);
    vecs++;
    if (fault !== 1'b0) begin
      $display("FAIL %s_early: fault=%0b, required 0", name, fault);
      errs++;
    end
    step(1);
    vecs++;
    if (fault !== 1'b1 || fault_code !== code) begin
      $display("FAIL %s: fault=%0b code=%0d, required 1/%0d", name, fault, fault_code, code);
      errs++;
    end
  endtask

  task test_seq_error();
    do_reset(0);
    step(2);
    run_cycle();
    hold(61);
    set_ph(2);
    expect_code_after_change("seq_error", 3'd2);
  endtask

  task test_short_yellow();
    do_reset(0);
    step(2);
    run_cycle();
    hold(61);
    set_ph(1);
    hold(5);
    set_ph(2);
    expect_code_after_change("short_yellow", 3'd4);
  endtask

  task test_short_green();
    do_reset(0);
    step(2);
    run_cycle();
    hold(29);
    set_ph(1);
    expect_code_after_change("short_green", 3'd3);
  endtask

  task test_long(input string name, input int p, input int limit, input logic [2:0] code);
    int target;
    do_reset(p);
    target = first_tick(1) + limit * CF;
    wait_edge(target);
    vecs++;
    if (fault !== 1'b0) begin
      $display("FAIL %s_early: fault=%0b at edge %0d, required 0", name, fault, edge_cnt);
      errs++;
    end
    step(1);
    vecs++;
    if (fault !== 1'b1 || fault_code !== code || flash_red !== 1'b1) begin
      $display("FAIL %s: fault=%0b code=%0d flash=%0b, required 1/%0d/1",
               name, fault, fault_code, flash_red, code);
      errs++;
    end
  endtask

  task test_ack_relock();
    set_ph(0);
    step(1);
    vecs++;
    if (fault !== 1'b1 || fault_code !== 3'd6) begin
      $display("FAIL ack_ignore_lamps: fault=%0b code=%0d, required 1/6", fault, fault_code);
      errs++;
    end
    fault_ack = 1'b1;
    step(1);
    fault_ack = 1'b0;
    vecs++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || phase_valid !== 1'b0 || flash_red !== 1'b0) begin
      $display("FAIL ack_clear: fault=%0b code=%0d valid=%0b flash=%0b, required 0/0/0/0",
               fault, fault_code, phase_valid, flash_red);
      errs++;
    end
    step(1);
    vecs++;
    if (phase_valid !== 1'b1 || phase !== 2'd0) begin
      $display("FAIL ack_relock: valid=%0b phase=%0d, required 1/0", phase_valid, phase);
      errs++;
    end
    fault_ack = 1'b1;
    step(1);
    fault_ack = 1'b0;
    vecs++;
    if (phase_valid !== 1'b1 || fault !== 1'b0) begin
      $display("FAIL ack_in_track: valid=%0b fault=%0b, required 1/0", phase_valid, fault);
      errs++;
    end
    hold(3);
    set_ph(1);
    hold(2);
    vecs++;
    if (fault !== 1'b0 || phase !== 2'd1) begin
      $display("FAIL relock_no_min: fault=%0b phase=%0d, required 0/1", fault, phase);
      errs++;
    end
    hold(8);
    set_ph(2);
    step(2);
    vecs++;
    if (fault !== 1'b0 || phase !== 2'd2) begin
      $display("FAIL relock_yellow_ok: fault=%0b phase=%0d, required 0/2", fault, phase);
      errs++;
    end
  endtask

  task test_ack_same_cycle();
    do_reset(0);
    step(3);
    set_l(3'b000, 3'b000);
    step(1);
    fault_ack = 1'b1;
    step(1);
    fault_ack = 1'b0;
    vecs++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      $display("FAIL ack_same_cycle: fault=%0b code=%0d, required 1/1", fault, fault_code);
      errs++;
    end
    step(1);
    vecs++;
    if (fault !== 1'b1) begin
      $display("FAIL ack_same_cycle_hold: fault=%0b, required 1", fault);
      errs++;
    end
  endtask

  task test_async_clear();
    #2;
    clear_n = 1'b0;
    #1;
    vecs++;
    if ({fault, flash_red, fault_code, phase_valid, phase} !== 8'd0) begin
      $display("FAIL async_clear: got %b, required 00000000",
               {fault, flash_red, fault_code, phase_valid, phase});
      errs++;
    end
    step(1);
    clear_n = 1'b1;
  endtask

  initial begin
    set_ph(0);
    test_reset();
    test_full_cycle();
    test_illegal();
    test_seq_error();
    test_short_yellow();
    test_short_green();
    test_long("long_cg", 2, 32, 3'd6);
    test_ack_relock();
    test_ack_same_cycle();
    test_long("long_hy", 1, 11, 3'd5);
    test_async_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ts_lamp_monitor.md
Name: ts_lamp_monitor

Overview:
- Independent conflict and timing monitor on the six lamp drives produced by the traffic-signal controller.
- Decodes each lamp pattern into a phase, tracks the phase sequence, and times each phase in seconds from its own 1 s tick.
- On any illegal pattern, out-of-order transition or timing violation, latches a fault code and raises a flash-red override request.

Parameters:
- CLK_FREQ, 50000000: clock cycles per second; sims use 10.
- HWY_GRN_MIN_S, 60: minimum highway-green duration, seconds.
- YEL_MIN_S, 10: nominal yellow duration, seconds; used as both minimum and maximum.
- CTRY_GRN_MAX_S, 31: maximum country-green duration, seconds.
- TOL_S, 1: tolerance for unsynchronised ticks, seconds.

Ports:
- clk  in  1  system clock
- clear_n  in  1  asynchronous active-low reset
- R_ctry, G_ctry, Y_ctry  in  1 each  country lamp drives, same clock domain
- R_hiwy, G_hiwy, Y_hiwy  in  1 each  highway lamp drives
- fault_ack  in  1  single-cycle pulse; clears a latched fault
- phase  out  2  last legal phase: 0=HG, 1=HY, 2=CG, 3=CY
- phase_valid  out  1  high while tracking a legal phase
- fault  out  1  latched fault flag
- fault_code  out  3  cause of the latched fault
- flash_red  out  1  override request; equals fault

Behaviour:
- Reset (clear_n low, asynchronous): all outputs 0, FSM in INIT, tick counter 0, elapsed 0, lamp register 0.
- Lamp inputs are registered once. All decoding and checking uses the registered copy.
- Legal patterns, written {R,G,Y}:
  - HG: hiwy=010, ctry=100
  - HY: hiwy=001, ctry=100
  - CG: hiwy=100, ctry=010
  - CY: hiwy=100, ctry=001
  - Any other pattern, including all-red, all-off or two greens, is illegal.
- Tick counter: free-running modulo CLK_FREQ. sec_tick is high for one cycle when the count wraps. It is reset only by clear_n.
- elapsed_s:
  - 7 bits; increments on sec_tick and saturates at 127.
  - Forced to 0 in the cycle a phase change is detected. On a phase change coinciding with sec_tick, the result is 0.
- FSM states:
  - INIT: phase_valid=0. On the first legal pattern, go to TRACK with first=1, load phase, and set elapsed to 0.
  - TRACK:
    - A pattern change to another legal phase must follow HG->HY->CG->CY->HG.
    - On a legal next-phase transition, the minimum check for the phase being left is applied, unless first=1. After the transition first=0.
    - The minimum is HWY_GRN_MIN_S-TOL_S for HG, and YEL_MIN_S-TOL_S for HY and CY.
    - Maximum checks run every cycle regardless of first:
      - HY or CY: elapsed_s > YEL_MIN_S+TOL_S.
      - CG: elapsed_s > CTRY_GRN_MAX_S+TOL_S.
      - HG: no maximum.
  - FAULT: latched. fault=1, flash_red=1, phase_valid=0. Lamp activity is ignored. Exit only on fault_ack (go to INIT, fault and fault_code to 0) or on reset.
- Fault codes:
  - 1: illegal pattern
  - 2: sequence error
  - 3: short highway green
  - 4: short yellow
  - 5: long yellow
  - 6: long country green
  - 0: none
- Priority when several faults occur in the same cycle: 1 > 2 > 3/4 > 5/6.
- Latency: a violating pattern presented before clock edge N is registered at edge N. fault and fault_code update at edge N+1. Maximum-duration faults assert on the edge after elapsed_s first exceeds its limit.
- Illegal patterns in INIT also fault with code 1.
- fault_ack in TRACK or INIT has no effect.
- fault_ack in the same cycle a new fault is detected (in INIT or TRACK) has no effect; the new fault latches.
- fault_ack in FAULT goes to INIT. Faults are re-evaluated starting the next cycle.
- Pattern held unchanged: no transition. Elapsed keeps counting and only the maximum checks apply.

Test Plan (CLK_FREQ=10):
- Full legal cycle HG 62 s, HY 10 s, CG 20 s, CY 10 s, back to HG -> fault stays 0; phase steps 0,1,2,3,0; phase_valid=1 after the first registered pattern.
- From HG drive hiwy=010 with ctry=010 -> fault=1, fault_code=1, flash_red=1 exactly two edges after the pattern is applied.
- After a full cycle, HG for 62 s then jump directly to CG -> fault_code=2 at the edge after CG is registered.
- After a full cycle, HG 62 s then HY held only 5 s then CG -> fault_code=4. Separately, after a full cycle, HG held only 30 s then HY -> fault_code=3.
- CG held 40 s -> fault_code=6 asserted one edge after elapsed_s reaches 33. HY held 15 s -> fault_code=5 one edge after elapsed_s reaches 12.
- Latch and clear:
  - With code 6 latched, pulse fault_ack -> fault=0, INIT, then re-lock on the next legal pattern with no minimum check on that first phase.
  - fault_ack coincident with a code-1 pattern -> fault remains 1.
  - Pull clear_n low mid-fault, asynchronously between edges -> all outputs 0 immediately.
